// File: rtl/read_mem_pkg.sv
// rtl/read_mem_pkg.sv - shared states, button codes and addresses for the read sequencer
package read_mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic [1:0] {CMD_RD6, CMD_RD0, CMD_SCAN} cmd_t;

  // Same codes as the button-driven writer; buttons are active-low
  localparam logic [2:0] BTN_NONE = 3'b111;
  localparam logic [2:0] BTN_RD6  = 3'b110;
  localparam logic [2:0] BTN_RD0  = 3'b101;
  localparam logic [2:0] BTN_SCAN = 3'b011;

  localparam int ADDR_RD6 = 6;
  localparam int ADDR_RD0 = 0;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - button synchronizer and press-event decoder
module btn_sync_edge
  import read_mem_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn,
  output logic             evt,
  output cmd_t             cmd
);

  logic [WIDTH-1:0] btn_m;
  logic [WIDTH-1:0] btn_s;
  logic [WIDTH-1:0] btn_p;
  logic             hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_m <= '1;
      btn_s <= '1;
      btn_p <= '1;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      btn_p <= btn_s;
    end
  end

  // An event needs a fully released previous sample, so a held button fires once
  always_comb begin
    cmd = CMD_RD6;
    hit = 1'b0;
    case (btn_s)
      WIDTH'(BTN_RD6):  begin cmd = CMD_RD6;  hit = 1'b1; end
      WIDTH'(BTN_RD0):  begin cmd = CMD_RD0;  hit = 1'b1; end
      WIDTH'(BTN_SCAN): begin cmd = CMD_SCAN; hit = 1'b1; end
      default:          begin cmd = CMD_RD6;  hit = 1'b0; end
    endcase
    evt = hit && (btn_p == WIDTH'(BTN_NONE));
  end

endmodule

// File: rtl/read_mem_seq.sv
// rtl/read_mem_seq.sv - button-driven read sequencer for the lab data memory
module read_mem_seq
  import read_mem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int SCAN_LEN = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [2:0]                          btn,
  output logic                                mem_rd_en,
  output logic [ADDR_W-1:0]                   mem_addr,
  input  logic [DATA_W-1:0]                   mem_rdata,
  output logic [DATA_W-1:0]                   data_out,
  output logic                                data_valid,
  output logic [DATA_W+$clog2(SCAN_LEN)-1:0]  sum_out,
  output logic                                sum_valid,
  output logic                                busy
);

  localparam int SUM_W = DATA_W + $clog2(SCAN_LEN);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam int CNT_W = $clog2(SCAN_LEN + 1);

  state_t            state, state_n;
  logic              evt;
  cmd_t              cmd;
  logic              accept;
  logic              last_wait;
  logic [LAT_W-1:0]  lat_cnt;
  logic [CNT_W-1:0]  words_left;
  logic [SUM_W-1:0]  acc, acc_n;
  logic              scan_cmd;

  btn_sync_edge #(.WIDTH(3)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .evt   (evt),
    .cmd   (cmd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // busy still covers the final strobe cycle, so events arriving then are dropped
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    last_wait = 1'b0;
    acc_n     = acc + SUM_W'(mem_rdata);
    case (state)
      IDLE: if (evt && !busy) begin
        accept  = 1'b1;
        state_n = REQ;
      end
      REQ:  state_n = WAIT;
      WAIT: if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
        last_wait = 1'b1;
        state_n   = (words_left == CNT_W'(1)) ? IDLE : REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sum_out    <= '0;
      sum_valid  <= 1'b0;
      busy       <= 1'b0;
      lat_cnt    <= '0;
      words_left <= '0;
      acc        <= '0;
      scan_cmd   <= 1'b0;
    end else begin
      mem_rd_en  <= (state_n == REQ);
      data_valid <= last_wait;
      sum_valid  <= 1'b0;

      if (accept) begin
        mem_addr   <= (cmd == CMD_RD6) ? ADDR_W'(ADDR_RD6) : ADDR_W'(ADDR_RD0);
        words_left <= (cmd == CMD_SCAN) ? CNT_W'(SCAN_LEN) : CNT_W'(1);
        scan_cmd   <= (cmd == CMD_SCAN);
        acc        <= '0;
        busy       <= 1'b1;
      end else if (state == IDLE) begin
        busy <= 1'b0;
      end

      if (state == REQ)                     lat_cnt <= '0;
      else if (state == WAIT && !last_wait) lat_cnt <= lat_cnt + LAT_W'(1);

      if (last_wait) begin
        data_out   <= mem_rdata;
        acc        <= acc_n;
        words_left <= words_left - CNT_W'(1);
        if (words_left == CNT_W'(1)) begin
          if (scan_cmd) begin
            sum_out   <= acc_n;
            sum_valid <= 1'b1;
          end
        end else begin
          mem_addr <= mem_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule
